// File: rtl/serial_subtractor_if.sv
// Handshake and result bundle for the bit-serial subtractor.
// The requester uses master; the subtractor uses slave.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;
  logic             zero;

  modport master (
    output start,
    output a_in,
    output b_in,
    input  busy,
    input  done,
    input  diff,
    input  borrow,
    input  ovf,
    input  zero
  );

  modport slave (
    input  start,
    input  a_in,
    input  b_in,
    output busy,
    output done,
    output diff,
    output borrow,
    output ovf,
    output zero
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor, one full-subtractor cell per cycle.
// Results are registered on the last shift and held until the next one.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_sr;
  logic [WIDTH-1:0] d_nxt;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             br_nxt;
  logic             d;
  logic             a_msb;
  logic             b_msb;
  logic             last;
  logic             busy;
  logic             done;

  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             ovf_q;
  logic             zero_q;

  assign last = (cnt == LAST);

  always_comb begin
    d      = a_sr[0] ^ b_sr[0] ^ br;
    br_nxt = (~a_sr[0] & b_sr[0])
           | (~(a_sr[0] ^ b_sr[0]) & br);
    d_nxt  = {d, d_sr[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      d_sr     <= '0;
      cnt      <= '0;
      br       <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr  <= bus.a_in;
            b_sr  <= bus.b_in;
            br    <= 1'b0;
            cnt   <= '0;
            a_msb <= bus.a_in[WIDTH-1];
            b_msb <= bus.b_in[WIDTH-1];
          end
        end
        SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          d_sr <= d_nxt;
          br   <= br_nxt;
          cnt  <= cnt + 1'b1;
          // d_nxt already holds the complete result on the last bit
          if (last) begin
            diff_q   <= d_nxt;
            borrow_q <= br_nxt;
            zero_q   <= (d_nxt == '0);
            ovf_q    <= (a_msb != b_msb)
                     && (d_nxt[WIDTH-1] != a_msb);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
  assign bus.ovf    = ovf_q;
  assign bus.zero   = zero_q;
endmodule
